// File: rtl/alu_core.sv
// Sequenced ALU feeding the ALU result register: one-cycle logic/arithmetic ops,
// WIDTH-cycle shift-add multiply, start/ready handshake and a one-cycle load strobe.
module alu_core #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             ld_alureg,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam logic [2:0]       OP_MUL = 3'b111;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    state_t               state, state_next;
    logic [2:0]           op_p0;
    logic [WIDTH-1:0]     a_p0, b_p0;
    logic [2*WIDTH-1:0]   acc, mcand, acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     count;
    logic [WIDTH:0]       exec_out;
    logic [WIDTH-1:0]     fin_res;
    logic                 fin_c;
    logic                 complete;

    // Returns {carry, result} for every single-cycle opcode.
    function automatic logic [WIDTH:0] alu_op(input logic [2:0] code,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (code)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {(a < b), a - b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            3'b110:  r = {a[0], 1'b0, a[WIDTH-1:1]};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (op == OP_MUL) ? MUL : EXEC;
            EXEC:    state_next = DONE;
            MUL:     if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign exec_out = alu_op(op_p0, a_p0, b_p0);
    assign complete = (state == EXEC) || ((state == MUL) && (count == LAST));
    assign fin_res  = (state == MUL) ? acc_next[WIDTH-1:0] : exec_out[WIDTH-1:0];
    assign fin_c    = (state == MUL) ? |acc_next[2*WIDTH-1:WIDTH] : exec_out[WIDTH];

    // Operand latch, multiply iteration and completion register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_p0  <= '0;
            a_p0   <= '0;
            b_p0   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_p0  <= op;
                a_p0   <= op_a;
                b_p0   <= op_b;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, op_a};
                mplier <= op_b;
                count  <= '0;
            end
            if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CNT_W'(1);
            end
            if (complete) begin
                result <= fin_res;
                flag_z <= (fin_res == '0);
                flag_c <= fin_c;
                flag_n <= fin_res[WIDTH-1];
            end
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = (state == EXEC) || (state == MUL);
    assign ld_alureg = (state == DONE);

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: hand-computed vectors, handshake timing,
// ignored start while busy, and reset in the middle of a multiply.
module tb_alu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       ready, busy, ld_alureg, flag_z, flag_c, flag_n;
    logic [7:0] result;

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    int busy_cnt;
    int ld_cnt;

    alu_core #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .ready(ready), .busy(busy), .result(result), .ld_alureg(ld_alureg),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int res, input int z, input int c, input int n);
        check({tag, ".result"}, int'(result), res);
        check({tag, ".z"}, int'(flag_z), z);
        check({tag, ".c"}, int'(flag_c), c);
        check({tag, ".n"}, int'(flag_n), n);
    endtask

    task automatic chk_ctl(input string tag, input int rdy, input int bsy, input int ld);
        check({tag, ".ready"}, int'(ready), rdy);
        check({tag, ".busy"}, int'(busy), bsy);
        check({tag, ".ld"}, int'(ld_alureg), ld);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge (edge N); returns 1ns after edge N.
    task automatic launch(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
        op_a  = 8'hAA;
        op_b  = 8'h55;
    endtask

    // Advances until ld_alureg is seen; cyc holds edges elapsed since edge N.
    task automatic wait_ld(input int start_cyc);
        cyc = start_cyc;
        busy_cnt = 0;
        while (!ld_alureg && cyc < 30) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
    endtask

    initial begin
        step();
        step();
        chk_ctl("reset", 1, 0, 0);
        chk_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step();

        launch(3'b000, 8'hFF, 8'h01);
        chk_ctl("add_exec", 0, 1, 0);
        wait_ld(0);
        check("add_latency", cyc, 1);
        chk_out("add", 8'h00, 1, 1, 0);
        step();
        chk_ctl("add_after", 1, 0, 0);
        chk_out("add_hold", 8'h00, 1, 1, 0);

        launch(3'b001, 8'h05, 8'h07);
        wait_ld(0);
        chk_out("sub", 8'hFE, 0, 1, 1);
        step();
        launch(3'b010, 8'hF0, 8'h0F);
        wait_ld(0);
        chk_out("and", 8'h00, 1, 0, 0);
        step();

        launch(3'b111, 8'h0D, 8'h0B);
        busy_cnt = 0;
        cyc = 0;
        while (!ld_alureg && cyc < 30) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
        check("mul_latency", cyc, 8);
        check("mul_busy_cycles", busy_cnt, 8);
        chk_out("mul", 8'h8F, 0, 0, 1);
        step();

        launch(3'b111, 8'h20, 8'h10);
        wait_ld(0);
        chk_out("mul_ovf", 8'h00, 1, 1, 0);
        step();
        launch(3'b101, 8'h81, 8'h00);
        wait_ld(0);
        chk_out("shl", 8'h02, 0, 1, 0);
        step();
        launch(3'b110, 8'h81, 8'h00);
        wait_ld(0);
        chk_out("shr", 8'h40, 0, 1, 0);
        step();

        launch(3'b111, 8'h0D, 8'h0B);
        step();
        step();
        start = 1'b1;
        op    = 3'b000;
        op_a  = 8'h01;
        op_b  = 8'h01;
        chk_ctl("mul_ign_busy", 0, 1, 0);
        step();
        start = 1'b0;
        wait_ld(3);
        check("mul_ign_latency", cyc, 8);
        chk_out("mul_ign", 8'h8F, 0, 0, 1);
        ld_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ld_alureg) ld_cnt++;
        end
        check("mul_ign_extra_ld", ld_cnt, 0);
        chk_ctl("mul_ign_idle", 1, 0, 0);
        chk_out("mul_ign_hold", 8'h8F, 0, 0, 1);

        launch(3'b111, 8'h0D, 8'h0B);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk_ctl("rst_mid_mul", 1, 0, 0);
        chk_out("rst_mid_mul", 0, 0, 0, 0);
        rst = 1'b0;
        ld_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ld_alureg) ld_cnt++;
        end
        check("rst_no_ld", ld_cnt, 0);
        launch(3'b000, 8'h02, 8'h03);
        wait_ld(0);
        check("add_post_rst_latency", cyc, 1);
        chk_out("add_post_rst", 8'h05, 0, 0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
